multicycle_control_unit: RTL and testbench

Moore-style sequencing FSM for the multi-cycle MIPS core. It replaces the single-cycle decoder as the core's controller. It steps each instruction through IF/ID/EXE/MEM/WB and drives the same datapath control set per state. It adds PCWre/IRWre gating so the PC and instruction register update only at instruction boundaries. It sits between the instruction register (op source) and the PC, register file, ALU and data memory.

---
 rtl/mcu_pkg.sv | 38 +++
 rtl/mcu_decode.sv | 54 +++++
 rtl/multicycle_control_unit.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared opcode, state-encoding and ALU function constants for the
// multi-cycle MIPS controller.
package mcu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b011011;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

endpackage

// File: rtl/mcu_decode.sv
// Combinational opcode decoder: instruction-class one-hots plus the
// op-derived datapath fields (register destination, ALU sources, extension, ALU function).
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [5:0] op_i,
    output logic       is_alu_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic       is_beq_o,
    output logic       is_bne_o,
    output logic       is_j_o,
    output logic       is_halt_o,
    output logic       reg_dst_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic       ext_sel_o,
    output logic [2:0] alu_op_o
);

    // Opcode to class and field decode; unknown opcodes leave every flag clear
    always_comb begin
        is_alu_o    = 1'b0;
        is_lw_o     = 1'b0;
        is_sw_o     = 1'b0;
        is_beq_o    = 1'b0;
        is_bne_o    = 1'b0;
        is_j_o      = 1'b0;
        is_halt_o   = 1'b0;
        reg_dst_o   = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        ext_sel_o   = 1'b0;
        alu_op_o    = ALU_ADD;
        case (op_i)
            OP_ADD:  begin is_alu_o = 1'b1; reg_dst_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_ADDI: begin is_alu_o = 1'b1; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_SUB:  begin is_alu_o = 1'b1; reg_dst_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_ORI:  begin is_alu_o = 1'b1; alu_src_b_o = 1'b1; alu_op_o = ALU_OR; end
            OP_AND:  begin is_alu_o = 1'b1; reg_dst_o = 1'b1; alu_op_o = ALU_AND; end
            OP_OR:   begin is_alu_o = 1'b1; reg_dst_o = 1'b1; alu_op_o = ALU_OR; end
            OP_SLL:  begin is_alu_o = 1'b1; reg_dst_o = 1'b1; alu_src_a_o = 1'b1; alu_op_o = ALU_SLL; end
            OP_SLTI: begin is_alu_o = 1'b1; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_SLT; end
            OP_SW:   begin is_sw_o = 1'b1; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_LW:   begin is_lw_o = 1'b1; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_BEQ:  begin is_beq_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_BNE:  begin is_bne_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_J:    begin is_j_o = 1'b1; end
            OP_HALT: begin is_halt_o = 1'b1; end
            default: begin is_alu_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencing FSM for the multi-cycle MIPS core: steps each instruction
// through IF/ID/EXE/MEM/WB and gates PC/IR writes to instruction boundaries.
module multicycle_control_unit
    import mcu_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       RegDst,
    output logic       ExtSel,
    output logic [1:0] PcSrc,
    output logic [2:0] ALUOp,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    logic       halted_q, halted_d;

    logic       is_alu_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s, is_j_s, is_halt_s;
    logic       reg_dst_s, alu_src_a_s, alu_src_b_s, ext_sel_s;
    logic [2:0] alu_op_s;
    logic       br_taken_s;

    mcu_decode u_decode (
        .op_i        (op),
        .is_alu_o    (is_alu_s),
        .is_lw_o     (is_lw_s),
        .is_sw_o     (is_sw_s),
        .is_beq_o    (is_beq_s),
        .is_bne_o    (is_bne_s),
        .is_j_o      (is_j_s),
        .is_halt_o   (is_halt_s),
        .reg_dst_o   (reg_dst_s),
        .alu_src_a_o (alu_src_a_s),
        .alu_src_b_o (alu_src_b_s),
        .ext_sel_o   (ext_sel_s),
        .alu_op_o    (alu_op_s)
    );

    assign br_taken_s = (is_beq_s & zero) | (is_bne_s & ~zero);

    // State and halt-flag registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic; once halted the FSM parks on the ID encoding until reset
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halted_q) begin
            state_d = S_ID;
        end else begin
            case (state_q)
                S_IF:     state_d = S_ID;
                S_ID: begin
                    if (is_alu_s) begin
                        state_d = S_EXE_AL;
                    end else if (is_lw_s || is_sw_s) begin
                        state_d = S_EXE_LS;
                    end else if (is_beq_s || is_bne_s) begin
                        state_d = S_EXE_BR;
                    end else if (is_halt_s) begin
                        state_d  = S_ID;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_IF;
                    end
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_WB_AL:  state_d = S_IF;
                S_EXE_LS: state_d = S_MEM;
                S_MEM: begin
                    if (is_lw_s) begin
                        state_d = S_WB_LD;
                    end else begin
                        state_d = S_IF;
                    end
                end
                S_WB_LD:  state_d = S_IF;
                S_EXE_BR: state_d = S_IF;
                default:  state_d = S_IF;
            endcase
        end
    end

    // Per-state control outputs; reset forces everything low, halt clears all enables
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PcSrc     = 2'b00;
        RegDst    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        state     = 3'b000;
        if (Reset) begin
            state = 3'b000;
        end else begin
            state   = state_q;
            RegDst  = reg_dst_s;
            ALUSrcA = alu_src_a_s;
            ALUSrcB = alu_src_b_s;
            ExtSel  = ext_sel_s;
            ALUOp   = alu_op_s;
            if (halted_q) begin
                PCWre = 1'b0;
            end else begin
                case (state_q)
                    S_IF: begin
                        IRWre    = 1'b1;
                        InsMemRW = 1'b1;
                    end
                    S_ID: begin
                        // j and unknown opcodes retire here
                        if (is_j_s) begin
                            PCWre = 1'b1;
                            PcSrc = 2'b10;
                        end else if (!(is_alu_s || is_lw_s || is_sw_s || is_beq_s || is_bne_s || is_halt_s)) begin
                            PCWre = 1'b1;
                        end else begin
                            PCWre = 1'b0;
                        end
                    end
                    S_EXE_BR: begin
                        PCWre = 1'b1;
                        PcSrc = br_taken_s ? 2'b01 : 2'b00;
                    end
                    S_WB_AL: begin
                        PCWre  = 1'b1;
                        RegWre = 1'b1;
                    end
                    S_MEM: begin
                        mRD   = is_lw_s;
                        mWR   = is_sw_s;
                        PCWre = is_sw_s;
                    end
                    S_WB_LD: begin
                        PCWre     = 1'b1;
                        RegWre    = 1'b1;
                        DBDataSrc = 1'b1;
                    end
                    default: PCWre = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: table of instruction
// vectors with per-cycle expected state/controls fed through a scoreboard queue.
module tb_multicycle_control_unit;

    logic       CLK, Reset, zero;
    logic [5:0] op;
    logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, DBDataSrc;
    logic       mRD, mWR, RegDst, ExtSel;
    logic [1:0] PcSrc;
    logic [2:0] ALUOp, state;

    multicycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .RegDst(RegDst), .ExtSel(ExtSel),
        .PcSrc(PcSrc), .ALUOp(ALUOp), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ctl bits: {PCWre, IRWre, InsMemRW, RegWre, DBDataSrc, mRD, mWR, PcSrc[1:0]}
    localparam logic [8:0] C_IF    = 9'b0_1_1_0_0_0_0_00;
    localparam logic [8:0] C_NONE  = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] C_IDJ   = 9'b1_0_0_0_0_0_0_10;
    localparam logic [8:0] C_RET   = 9'b1_0_0_0_0_0_0_00;
    localparam logic [8:0] C_BRT   = 9'b1_0_0_0_0_0_0_01;
    localparam logic [8:0] C_WBAL  = 9'b1_0_0_1_0_0_0_00;
    localparam logic [8:0] C_MEMLW = 9'b0_0_0_0_0_1_0_00;
    localparam logic [8:0] C_MEMSW = 9'b1_0_0_0_0_0_1_00;
    localparam logic [8:0] C_WBLD  = 9'b1_0_0_1_1_0_0_00;

    typedef struct {
        string             name;
        logic [5:0]        op;
        logic              zero;
        int                ncyc;
        logic              chk_dec;
        logic [6:0]        dec;   // {RegDst, ALUSrcA, ALUSrcB, ExtSel, ALUOp}
        logic [4:0][11:0]  cyc;   // per cycle {state, ctl}
    } vec_t;

    vec_t        vecs[16];
    logic [11:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [11:0] r(input logic [2:0] s, input logic [8:0] c);
        return {s, c};
    endfunction

    function automatic vec_t mk(input string n, input logic [5:0] o, input logic z, input int nc,
                                input logic cd, input logic [6:0] d,
                                input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c2,
                                input logic [11:0] c3, input logic [11:0] c4);
        vec_t v;
        v.name = n; v.op = o; v.zero = z; v.ncyc = nc; v.chk_dec = cd; v.dec = d;
        v.cyc[0] = c0; v.cyc[1] = c1; v.cyc[2] = c2; v.cyc[3] = c3; v.cyc[4] = c4;
        return v;
    endfunction

    task automatic step(input logic [11:0] exp, input logic chk_dec, input logic [6:0] exp_dec,
                        input string name);
        logic [11:0] got, e;
        logic [6:0]  gd;
        sb_q.push_back(exp);
        @(negedge CLK);
        got = {state, PCWre, IRWre, InsMemRW, RegWre, DBDataSrc, mRD, mWR, PcSrc};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s state/ctl got %h expected %h", name, got, e);
        end
        if (chk_dec) begin
            gd = {RegDst, ALUSrcA, ALUSrcB, ExtSel, ALUOp};
            checks++;
            if (gd !== exp_dec) begin
                errors++;
                $display("FAIL %s decode got %b expected %b", name, gd, exp_dec);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string name);
        logic [19:0] all;
        all = {PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, mRD, mWR,
               RegDst, ExtSel, PcSrc, ALUOp, state};
        checks++;
        if (all !== 20'd0) begin
            errors++;
            $display("FAIL %s outputs got %h expected 0", name, all);
        end
    endtask

    task automatic run_vec(input vec_t v);
        op = v.op;
        for (int k = 0; k < v.ncyc; k++) begin
            if (v.ncyc == 3 && k == 2) zero = v.zero;
            else zero = 1'($urandom_range(0, 1));
            step(v.cyc[k], (k == 1) ? v.chk_dec : 1'b0, v.dec, v.name);
        end
    endtask

    initial begin
        logic [11:0] rif, rid, rexal, rwbal, rexls, rexbr;
        rif   = r(3'b000, C_IF);
        rid   = r(3'b001, C_NONE);
        rexal = r(3'b110, C_NONE);
        rwbal = r(3'b111, C_WBAL);
        rexls = r(3'b010, C_NONE);
        rexbr = r(3'b101, C_BRT);

        vecs[0]  = mk("add",  6'b000000, 1'b0, 4, 1'b1, 7'b1000_000, rif, rid, rexal, rwbal, 12'd0);
        vecs[1]  = mk("addi", 6'b000001, 1'b0, 4, 1'b1, 7'b0011_000, rif, rid, rexal, rwbal, 12'd0);
        vecs[2]  = mk("sub",  6'b000010, 1'b0, 4, 1'b1, 7'b1000_001, rif, rid, rexal, rwbal, 12'd0);
        vecs[3]  = mk("ori",  6'b010000, 1'b0, 4, 1'b1, 7'b0010_011, rif, rid, rexal, rwbal, 12'd0);
        vecs[4]  = mk("and",  6'b010001, 1'b0, 4, 1'b1, 7'b1000_100, rif, rid, rexal, rwbal, 12'd0);
        vecs[5]  = mk("or",   6'b010010, 1'b0, 4, 1'b1, 7'b1000_011, rif, rid, rexal, rwbal, 12'd0);
        vecs[6]  = mk("sll",  6'b011000, 1'b0, 4, 1'b1, 7'b1100_010, rif, rid, rexal, rwbal, 12'd0);
        vecs[7]  = mk("slti", 6'b011011, 1'b0, 4, 1'b1, 7'b0011_110, rif, rid, rexal, rwbal, 12'd0);
        vecs[8]  = mk("sw",   6'b100110, 1'b0, 4, 1'b1, 7'b0011_000, rif, rid, rexls,
                      r(3'b011, C_MEMSW), 12'd0);
        vecs[9]  = mk("lw",   6'b100111, 1'b0, 5, 1'b1, 7'b0011_000, rif, rid, rexls,
                      r(3'b011, C_MEMLW), r(3'b100, C_WBLD));
        vecs[10] = mk("beq_z1", 6'b110000, 1'b1, 3, 1'b1, 7'b0001_001, rif, rid, rexbr, 12'd0, 12'd0);
        vecs[11] = mk("beq_z0", 6'b110000, 1'b0, 3, 1'b1, 7'b0001_001, rif, rid,
                      r(3'b101, C_RET), 12'd0, 12'd0);
        vecs[12] = mk("bne_z0", 6'b110001, 1'b0, 3, 1'b1, 7'b0001_001, rif, rid, rexbr, 12'd0, 12'd0);
        vecs[13] = mk("bne_z1", 6'b110001, 1'b1, 3, 1'b1, 7'b0001_001, rif, rid,
                      r(3'b101, C_RET), 12'd0, 12'd0);
        vecs[14] = mk("j",    6'b111000, 1'b0, 2, 1'b0, 7'b0, rif, r(3'b001, C_IDJ), 12'd0, 12'd0, 12'd0);
        vecs[15] = mk("unk",  6'b001111, 1'b0, 2, 1'b0, 7'b0, rif, r(3'b001, C_RET), 12'd0, 12'd0, 12'd0);

        Reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        #12;
        chk_zero("reset_init");
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of an ALU instruction
        op = 6'b000000;
        step(rif, 1'b0, 7'd0, "rst_mid_if");
        step(rid, 1'b0, 7'd0, "rst_mid_id");
        #2;
        Reset = 1'b1;
        #1;
        chk_zero("rst_mid_async");
        @(posedge CLK);
        #1;
        chk_zero("rst_mid_held");
        Reset = 1'b0;
        run_vec(vecs[0]);

        // Halt: parks on ID encoding with all enables low, ignores op and zero
        op = 6'b111111;
        step(rif, 1'b0, 7'd0, "halt_if");
        step(rid, 1'b0, 7'd0, "halt_id");
        for (int i = 0; i < 20; i++) begin
            zero = 1'($urandom_range(0, 1));
            if (i == 5) op = 6'b111000;
            if (i == 12) op = 6'b000000;
            step(rid, 1'b0, 7'd0, "halted");
        end
        Reset = 1'b1;
        #2;
        chk_zero("halt_reset");
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        run_vec(vecs[9]);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
